lab7_2_spi_seq: RTL and testbench
=================================

LAB7_2_SPI_SEQ -- requirements
Module: lab7_2_spi_seq

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-002 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-003 SHALL have port cmd_valid, input, 1: burst request; cmd_len is valid while high.
REQ-004 SHALL have port cmd_len, input, 4: byte count of the burst (0 means 16).
REQ-005 SHALL have port cmd_ready, output, 1: high only in IDLE; a command is accepted when cmd_valid & cmd_ready.
REQ-006 SHALL have ports tx_data (input, 8), tx_valid (input, 1) and tx_ready (output, 1): TX byte stream with valid/ready handshake.
REQ-007 SHALL have ports rx_data (output, 8), rx_valid (output, 1) and rx_ready (input, 1): RX byte stream with valid/ready handshake.
REQ-008 SHALL have ports busy (output, 1), done (output, 1, single-cycle pulse) and err (output, 1, sticky).
REQ-009 SHALL have SPI-core side ports spi_select (out, 1), mem_addr (out, 3), read_n (out, 1), write_n (out, 1), data_from_cpu (out, 16), data_to_cpu (in, 16), readyfordata (in, 1) and dataavailable (in, 1).

Function
REQ-010 SHALL implement states IDLE, SSO_ON, WAIT_TX, WR_TX, WAIT_RX, RD_RX, PUSH_RX, SSO_OFF.
REQ-011 Every SPI-core access SHALL last exactly 2 cycles, with spi_select=1, fixed mem_addr/data_from_cpu, and read_n=0 or write_n=0; between accesses spi_select=0, read_n=1, write_n=1, and at least 1 idle cycle.
REQ-012 In IDLE, on command accept, the block SHALL latch count = cmd_len (0 maps to 16), clear err, and enter SSO_ON.
REQ-013 SSO_ON SHALL write addr 3 with data 0x0400 (SSO set, all IRQ enables 0), then enter WAIT_TX.
REQ-014 WAIT_TX SHALL wait for tx_valid & readyfordata; tx_ready SHALL pulse for 1 cycle in that cycle; the byte SHALL be latched and the state SHALL become WR_TX.
REQ-015 WR_TX SHALL write addr 1 with data {8'h00, byte}, then enter WAIT_RX.
REQ-016 WAIT_RX SHALL wait for dataavailable=1, then enter RD_RX.
REQ-017 RD_RX SHALL issue a 2-cycle read of addr 0, capture data_to_cpu[7:0] in the 2nd cycle, then enter PUSH_RX.
REQ-018 PUSH_RX SHALL hold rx_valid=1 with stable rx_data until rx_ready; on that handshake it SHALL decrement count and go to WAIT_TX if count≠0, else to SSO_OFF.
REQ-019 SSO_OFF SHALL write addr 3 with data 0x0000, pulse done for 1 cycle on completion, and return to IDLE.
REQ-020 busy SHALL be 0 only in IDLE.
REQ-021 tx_ready SHALL be 0 outside WAIT_TX, and rx_valid SHALL be 0 outside PUSH_RX.
REQ-022 cmd_valid SHALL be ignored while busy; a new command SHALL be accepted no earlier than the cycle after done.
REQ-023 The block SHALL never issue a data write while readyfordata=0, so the core never raises TOE.

Reset
REQ-024 While reset_n=0 at a clk edge, the block SHALL enter IDLE; spi_select=0, read_n=1, write_n=1, mem_addr=0, data_from_cpu=0, rx_data=0, rx_valid=0, tx_ready=0, done=0, err=0, busy=0, count=0.
REQ-025 A reset mid-burst SHALL abort immediately with no SSO_OFF write; the core's own reset restores SS.

Configuration
REQ-026 Macro SPI_SEQ_TIMEOUT_EN, when defined, SHALL add an 8-bit watchdog counter, cleared on entry to WAIT_RX and incremented each WAIT_RX cycle.
REQ-027 With SPI_SEQ_TIMEOUT_EN, if the counter reaches 255 in WAIT_RX, the block SHALL set err=1, skip the remaining bytes, and go to SSO_OFF, which still pulses done.
REQ-028 Without SPI_SEQ_TIMEOUT_EN, WAIT_RX SHALL wait indefinitely and err SHALL be tied to 0.

Verification
REQ-029 Single byte: cmd_len=1, tx 0xA5, core model echoes MISO=0x3C -> access order wr3(0x0400), wr1(0x00A5), rd0, wr3(0x0000); rx_data=0x3C; one done pulse.
REQ-030 Burst: cmd_len=0 -> exactly 16 wr1/rd0 pairs, in order, under a single SSO window.
REQ-031 Backpressure: rx_ready low for 50 cycles on byte 2 of 3 -> rx_data stable; no addr 1 write until the handshake; final bytes correct.
REQ-032 TX starvation: tx_valid low for 30 cycles mid-burst -> remains in WAIT_TX with no core accesses and SS held low; then resumes.
REQ-033 Timeout (macro on): dataavailable held 0 -> err=1 after 255 cycles; wr3(0x0000) issued; done pulses; next cmd clears err.
REQ-034 Reset mid-burst: reset_n low during RD_RX -> next cycle all outputs at reset values; cmd_ready=1.

Source files
------------

// File: rtl/lab7_2_spi_seq.sv
// SPI burst sequencer: drives a memory-mapped SPI core over 2-cycle accesses.
// Optional define SPI_SEQ_TIMEOUT_EN adds a WAIT_RX watchdog that sets err.
module lab7_2_spi_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [3:0]  cmd_len,
    output logic        cmd_ready,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        spi_select,
    output logic [2:0]  mem_addr,
    output logic        read_n,
    output logic        write_n,
    output logic [15:0] data_from_cpu,
    input  logic [15:0] data_to_cpu,
    input  logic        readyfordata,
    input  logic        dataavailable
);

    typedef enum logic [2:0] {
        IDLE, SSO_ON, WAIT_TX, WR_TX, WAIT_RX, RD_RX, PUSH_RX, SSO_OFF
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  ph, ph_nx, ph_step;
    logic        acc_on, acc_last;
    logic [4:0]  count;
    logic [7:0]  tx_byte;
    logic        unused_hi;

    // phases 0,1 drive the access, phase 2 is the mandatory idle gap
    assign acc_last  = (ph == 2'd2);
    assign acc_on    = !acc_last;
    assign ph_step   = acc_last ? 2'd0 : ph + 2'd1;
    assign unused_hi = ^data_to_cpu[15:8];

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rx_valid  = (state == PUSH_RX);

`ifdef SPI_SEQ_TIMEOUT_EN
    logic [7:0] wdog;
    logic       err_q;
    logic       wd_fire;
    assign wd_fire = (state == WAIT_RX) && !dataavailable && (wdog == 8'hff);
    assign err     = err_q;
`else
    assign err = 1'b0;
`endif

    // state and access-phase register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            ph    <= 2'd0;
        end else begin
            state <= state_nx;
            ph    <= ph_nx;
        end
    end

    // next state and core-bus / handshake outputs
    always_comb begin
        state_nx      = state;
        ph_nx         = 2'd0;
        spi_select    = 1'b0;
        read_n        = 1'b1;
        write_n       = 1'b1;
        mem_addr      = 3'd0;
        data_from_cpu = 16'h0000;
        tx_ready      = 1'b0;
        done          = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) state_nx = SSO_ON;
            end
            SSO_ON: begin
                spi_select = acc_on;
                write_n    = !acc_on;
                if (acc_on) begin
                    mem_addr      = 3'd3;
                    data_from_cpu = 16'h0400;
                end
                ph_nx = ph_step;
                if (acc_last) state_nx = WAIT_TX;
            end
            WAIT_TX: begin
                tx_ready = tx_valid && readyfordata;
                if (tx_valid && readyfordata) state_nx = WR_TX;
            end
            WR_TX: begin
                spi_select = acc_on;
                write_n    = !acc_on;
                if (acc_on) begin
                    mem_addr      = 3'd1;
                    data_from_cpu = {8'h00, tx_byte};
                end
                ph_nx = ph_step;
                if (acc_last) state_nx = WAIT_RX;
            end
            WAIT_RX: begin
                if (dataavailable) state_nx = RD_RX;
`ifdef SPI_SEQ_TIMEOUT_EN
                else if (wd_fire) state_nx = SSO_OFF;
`endif
            end
            RD_RX: begin
                spi_select = acc_on;
                read_n     = !acc_on;
                ph_nx      = ph_step;
                if (acc_last) state_nx = PUSH_RX;
            end
            PUSH_RX: begin
                if (rx_ready)
                    state_nx = (count == 5'd1) ? SSO_OFF : WAIT_TX;
            end
            SSO_OFF: begin
                spi_select = acc_on;
                write_n    = !acc_on;
                if (acc_on) mem_addr = 3'd3;
                ph_nx = ph_step;
                if (acc_last) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // burst datapath: byte count, tx/rx byte latches
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count   <= 5'd0;
            tx_byte <= 8'h00;
            rx_data <= 8'h00;
        end else begin
            if (state == IDLE && cmd_valid)
                count <= (cmd_len == 4'd0) ? 5'd16 : {1'b0, cmd_len};
            if (state == WAIT_TX && tx_ready)
                tx_byte <= tx_data;
            if (state == RD_RX && ph == 2'd1)
                rx_data <= data_to_cpu[7:0];
            if (state == PUSH_RX && rx_ready)
                count <= count - 5'd1;
        end
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    // watchdog on the wait for dataavailable; err is sticky until next command
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wdog  <= 8'h00;
            err_q <= 1'b0;
        end else begin
            if (state == WR_TX && acc_last)
                wdog <= 8'h00;
            else if (state == WAIT_RX)
                wdog <= wdog + 8'h01;
            if (state == IDLE && cmd_valid)
                err_q <= 1'b0;
            else if (wd_fire)
                err_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lab7_2_spi_seq.sv
// Self-checking bench for lab7_2_spi_seq with a simple SPI-core model.
// Timeout sequence is built only when SPI_SEQ_TIMEOUT_EN is defined.
module tb_lab7_2_spi_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_len = 4'd0;
    logic        cmd_ready;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        busy, done, err;
    logic        spi_select;
    logic [2:0]  mem_addr;
    logic        read_n, write_n;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu;
    logic        readyfordata = 1'b1;
    logic        dataavailable = 1'b0;

    lab7_2_spi_seq dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .done(done), .err(err),
        .spi_select(spi_select), .mem_addr(mem_addr),
        .read_n(read_n), .write_n(write_n),
        .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
        .readyfordata(readyfordata), .dataavailable(dataavailable)
    );

    always #5 clk = ~clk;

    localparam logic [20:0] WR3_ON  = {2'b10, 3'd3, 16'h0400};
    localparam logic [20:0] WR3_OFF = {2'b10, 3'd3, 16'h0000};
    localparam logic [20:0] RD0     = {2'b01, 3'd0, 16'h0000};

    typedef struct {
        logic [3:0] len;
        logic [7:0] seed;
        int         nbytes;
        int         tx_at;
        int         tx_cyc;
        int         rx_at;
        int         rx_cyc;
        logic [7:0] exp_rx0;
    } vec_t;

    vec_t        vecs [5];
    logic [20:0] exp_acc [$];
    int          n_tot = 0, n_bad = 0;
    int          m_tot = 0, m_bad = 0;
    int          done_cnt = 0;
    logic        quiet = 1'b0;
    logic        mon_off = 1'b0;
    logic        da_block = 1'b0;
    logic [7:0]  miso_q = 8'h00;

    assign data_to_cpu = {8'h5A, miso_q};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic mchk(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
        m_tot++;
        if (act !== exp) begin
            m_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // core model: echoes written byte ^ 0x99 a few cycles after each wr1
    initial begin
        int da_cnt;
        da_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                dataavailable = 1'b0;
                da_cnt = 0;
                miso_q = 8'h00;
            end else begin
                if (spi_select && !write_n && mem_addr == 3'd1) begin
                    miso_q = data_from_cpu[7:0] ^ 8'h99;
                    da_cnt = 3;
                end else if (da_cnt > 0) begin
                    da_cnt--;
                    if (da_cnt == 0 && !da_block) dataavailable = 1'b1;
                end
                if (spi_select && !read_n && mem_addr == 3'd0)
                    dataavailable = 1'b0;
            end
        end
    end

    // bus monitor: pops the expected access scoreboard
    initial begin
        logic       in_acc;
        int         sel_len;
        logic       prev_done;
        logic [20:0] e;
        in_acc = 1'b0;
        sel_len = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_off || !reset_n) begin
                in_acc = 1'b0;
                sel_len = 0;
                prev_done = 1'b0;
            end else begin
                if (spi_select) begin
                    if (!in_acc) begin
                        in_acc = 1'b1;
                        sel_len = 1;
                        mchk("no_access_in_stall", {31'd0, quiet}, 0);
                        if (exp_acc.size() == 0) begin
                            mchk("unexpected_access",
                                 {11'd0, read_n, write_n, mem_addr,
                                  data_from_cpu}, 0);
                        end else begin
                            e = exp_acc.pop_front();
                            mchk("access",
                                 {11'd0, read_n, write_n, mem_addr,
                                  data_from_cpu}, {11'd0, e});
                        end
                    end else begin
                        sel_len++;
                    end
                end else if (in_acc) begin
                    in_acc = 1'b0;
                    mchk("access_len", sel_len, 2);
                    mchk("idle_strobes", {30'd0, read_n, write_n}, 3);
                end
                if (done) begin
                    mchk("done_single", {31'd0, prev_done}, 0);
                    done_cnt++;
                end
                prev_done = done;
            end
        end
    end

    task automatic send_cmd(input logic [3:0] len);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_len = len;
        #1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("cmd_accept", {31'd0, cmd_ready}, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_tx(input logic [7:0] b);
        int n;
        n = 0;
        tx_valid = 1'b1;
        tx_data = b;
        #1;
        while (!tx_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk("tx_handshake", {31'd0, tx_ready}, 1);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic recv_rx(input logic [7:0] exp, input int stall);
        int n;
        logic [7:0] hold;
        n = 0;
        #1;
        while (!rx_valid && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk("rx_valid", {31'd0, rx_valid}, 1);
        if (stall > 0) begin
            hold = rx_data;
            quiet = 1'b1;
            repeat (stall) @(negedge clk);
            #1;
            chk("rx_stable", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, hold});
            quiet = 1'b0;
        end
        rx_ready = 1'b1;
        chk("rx_data", {24'd0, rx_data}, {24'd0, exp});
        @(posedge clk);
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit);
        int n;
        n = 0;
        #1;
        while (done_cnt == d0 && n < limit) begin
            @(negedge clk); #1; n++;
        end
        chk("done_seen", done_cnt, d0 + 1);
        @(negedge clk); #1;
        chk("idle_after_done", {30'd0, cmd_ready, busy}, 2);
        chk("scoreboard_empty", exp_acc.size(), 0);
    endtask

    task automatic run_burst(input vec_t v);
        int d0;
        logic [7:0] b;
        logic [7:0] exp;
        d0 = done_cnt;
        exp_acc.push_back(WR3_ON);
        for (int i = 0; i < v.nbytes; i++) begin
            b = v.seed + 8'(i);
            exp_acc.push_back({2'b10, 3'd1, 8'h00, b});
            exp_acc.push_back(RD0);
        end
        exp_acc.push_back(WR3_OFF);
        send_cmd(v.len);
        chk("err_cleared", {31'd0, err}, 0);
        for (int i = 0; i < v.nbytes; i++) begin
            b = v.seed + 8'(i);
            if (i == v.tx_at) begin
                quiet = 1'b1;
                repeat (v.tx_cyc) @(negedge clk);
                #1;
                chk("tx_starve_hold",
                    {29'd0, busy, spi_select, tx_ready}, 4);
                quiet = 1'b0;
            end
            send_tx(b);
            if (i == 0) chk("busy_blocks_cmd", {30'd0, busy, cmd_ready}, 2);
            exp = (i == 0) ? v.exp_rx0 : (b ^ 8'h99);
            recv_rx(exp, (i == v.rx_at) ? v.rx_cyc : 0);
        end
        wait_done(d0, 50);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        vec_t rv;
        int   n;
        vecs[0] = '{4'd1, 8'hA5,  1, -1,  0, -1,  0, 8'h3C};
        vecs[1] = '{4'd0, 8'h10, 16, -1,  0, -1,  0, 8'h89};
        vecs[2] = '{4'd3, 8'h40,  3, -1,  0,  1, 50, 8'hD9};
        vecs[3] = '{4'd4, 8'h77,  4,  2, 30, -1,  0, 8'hEE};
        vecs[4] = '{4'd2, 8'hF0,  2, -1,  0, -1,  0, 8'h69};

        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs",
            {spi_select, read_n, write_n, mem_addr, data_from_cpu, rx_data,
             rx_valid, tx_ready, done, err, busy, cmd_ready},
            {1'b0, 1'b1, 1'b1, 3'd0, 16'h0, 8'h0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 5; k++) run_burst(vecs[k]);

        // reset during the rx read access
        exp_acc.push_back(WR3_ON);
        exp_acc.push_back({2'b10, 3'd1, 8'h00, 8'h5C});
        exp_acc.push_back(RD0);
        send_cmd(4'd2);
        send_tx(8'h5C);
        n = 0;
        #1;
        while (!(spi_select && !read_n) && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk("reached_rd_rx", {30'd0, spi_select, read_n}, 2);
        mon_off = 1'b1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midburst_reset",
            {spi_select, read_n, write_n, mem_addr, data_from_cpu, rx_data,
             rx_valid, tx_ready, done, err, busy, cmd_ready},
            {1'b0, 1'b1, 1'b1, 3'd0, 16'h0, 8'h0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        reset_n = 1'b1;
        exp_acc.delete();
        @(negedge clk);
        mon_off = 1'b0;
        @(negedge clk);
        rv = '{4'd1, 8'h33, 1, -1, 0, -1, 0, 8'hAA};
        run_burst(rv);

`ifdef SPI_SEQ_TIMEOUT_EN
        begin
            int d0;
            d0 = done_cnt;
            da_block = 1'b1;
            exp_acc.push_back(WR3_ON);
            exp_acc.push_back({2'b10, 3'd1, 8'h00, 8'hE1});
            exp_acc.push_back(WR3_OFF);
            send_cmd(4'd3);
            send_tx(8'hE1);
            n = 0;
            #1;
            while (done_cnt == d0 && n < 400) begin
                @(negedge clk); #1; n++;
            end
            chk("timeout_done", done_cnt, d0 + 1);
            chk("timeout_err", {31'd0, err}, 1);
            chk("timeout_wait", {31'd0, (n >= 255)}, 1);
            @(negedge clk); #1;
            chk("timeout_idle", {30'd0, cmd_ready, err}, 3);
            chk("timeout_sb_empty", exp_acc.size(), 0);
            da_block = 1'b0;
            @(negedge clk);
            rv = '{4'd1, 8'h08, 1, -1, 0, -1, 0, 8'h91};
            run_burst(rv);
        end
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_tot + m_tot, n_bad + m_bad);
        $finish;
    end

endmodule
